// File: rtl/div_mc_if.sv
// Handshake and data bundle between the execute stage and the multi-cycle divider.
interface div_mc_if;
  logic        start_i;
  logic        signed_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stall_div_o;

  modport master (
    output start_i, signed_i, opdata1_i, opdata2_i, annul_i,
    input  result_o, ready_o, stall_div_o
  );

  modport slave (
    input  start_i, signed_i, opdata1_i, opdata2_i, annul_i,
    output result_o, ready_o, stall_div_o
  );
endinterface

// File: rtl/div_mc.sv
// Radix-2 restoring 32-bit divider (DIV/DIVU); result is {remainder, quotient}.
//   state     | meaning
//   S_IDLE    | waiting for start, operands sampled here only
//   S_DIVZERO | divisor was zero, zero result next cycle
//   S_ON      | one restoring iteration per cycle, 32 cycles
//   S_END     | result valid for one cycle, then back to idle
module div_mc (
  input logic   clk,
  input logic   resetn,
  div_mc_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_DIVZERO = 2'b01,
    S_ON      = 2'b10,
    S_END     = 2'b11
  } state_t;

  state_t      state, stateNext;
  logic [5:0]  cnt, cntNext;
  logic        negQuot, negQuotNext;
  logic        negRem, negRemNext;
  logic [31:0] divisor, divisorNext;
  logic [64:0] work, workNext;
  logic [63:0] result, resultNext;

  logic [31:0] absOp1, absOp2;
  logic [33:0] remShift, diff;
  logic        trialOk;
  logic [32:0] iterRem;
  logic [31:0] iterQuot;
  logic        abort;
  logic        readyInt;

  assign absOp1 = (bus.signed_i && bus.opdata1_i[31]) ? (~bus.opdata1_i + 32'd1) : bus.opdata1_i;
  assign absOp2 = (bus.signed_i && bus.opdata2_i[31]) ? (~bus.opdata2_i + 32'd1) : bus.opdata2_i;

  // Top 34 bits of the shifted work register against the divisor; bit 33 of diff is the borrow.
  assign remShift = work[64:31];
  assign diff     = remShift - {2'b00, divisor};
  assign trialOk  = ~diff[33];
  assign iterRem  = trialOk ? diff[32:0] : remShift[32:0];
  assign iterQuot = {work[30:0], trialOk};

  assign abort = bus.annul_i |
                 (~bus.start_i & ((state == S_ON) | (state == S_DIVZERO)));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= S_IDLE;
      cnt     <= 6'd0;
      negQuot <= 1'b0;
      negRem  <= 1'b0;
      divisor <= 32'd0;
      work    <= 65'd0;
      result  <= 64'd0;
    end else begin
      state   <= stateNext;
      cnt     <= cntNext;
      negQuot <= negQuotNext;
      negRem  <= negRemNext;
      divisor <= divisorNext;
      work    <= workNext;
      result  <= resultNext;
    end
  end

  always_comb begin
    stateNext   = state;
    cntNext     = cnt;
    negQuotNext = negQuot;
    negRemNext  = negRem;
    divisorNext = divisor;
    workNext    = work;
    resultNext  = result;
    case (state)
      S_IDLE: begin
        if (bus.start_i && !bus.annul_i) begin
          if (bus.opdata2_i == 32'd0) begin
            stateNext = S_DIVZERO;
          end else begin
            negQuotNext = bus.signed_i & (bus.opdata1_i[31] ^ bus.opdata2_i[31]);
            negRemNext  = bus.signed_i & bus.opdata1_i[31];
            workNext    = {33'd0, absOp1};
            divisorNext = absOp2;
            cntNext     = 6'd0;
            stateNext   = S_ON;
          end
        end
      end
      S_DIVZERO: begin
        resultNext = 64'd0;
        stateNext  = S_END;
      end
      S_ON: begin
        workNext = {iterRem, iterQuot};
        cntNext  = cnt + 6'd1;
        if (cnt == 6'd31) begin
          resultNext = {negRem  ? (~iterRem[31:0] + 32'd1) : iterRem[31:0],
                        negQuot ? (~iterQuot + 32'd1)      : iterQuot};
          stateNext  = S_END;
        end
      end
      S_END: begin
        stateNext = S_IDLE;
      end
      default: begin
        stateNext = S_IDLE;
      end
    endcase
    if (abort) begin
      stateNext = S_IDLE;
    end
  end

  // Annul in the END cycle suppresses the result in that same cycle.
  assign readyInt        = (state == S_END) & ~bus.annul_i;
  assign bus.ready_o     = readyInt;
  assign bus.result_o    = readyInt ? result : 64'd0;
  assign bus.stall_div_o = resetn & bus.start_i & ~readyInt & ~bus.annul_i;

endmodule

// File: tb/tb_div_mc.sv
// Self-checking bench for div_mc: directed corner cases plus randomized divides
// against an arithmetic reference model.
module tb_div_mc;

  logic clk;
  logic resetn;
  int   passCount;
  int   totalCount;

  div_mc_if bus ();

  div_mc dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] refDiv(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa = $signed(a);
      sb = $signed(b);
      q  = sa / sb;
      r  = sa % sb;
      return {r[31:0], q[31:0]};
    end
    return {a % b, a / b};
  endfunction

  // Starts a divide in the current cycle and runs until ready_o or a cycle budget.
  // Operands are scrambled after cycle 0 since the divider must not resample them.
  task automatic runOne(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        output logic [63:0] res, output int lat, output int stalls);
    bus.opdata1_i = a;
    bus.opdata2_i = b;
    bus.signed_i  = sgn;
    bus.start_i   = 1'b1;
    res    = 64'd0;
    lat    = -1;
    stalls = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (bus.stall_div_o === 1'b1) stalls++;
      if (bus.ready_o === 1'b1) begin
        res = bus.result_o;
        lat = c;
      end
      @(posedge clk);
      #1;
      if (lat >= 0) break;
      bus.opdata1_i = $urandom;
      bus.opdata2_i = $urandom;
    end
  endtask

  task automatic idleCycle();
    bus.start_i = 1'b0;
    @(negedge clk);
    totalCount++;
    if (bus.ready_o !== 1'b0)
      $display("FAIL ready_single_pulse: ready_o=%b required 0", bus.ready_o);
    else passCount++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn        = 1'b0;
    bus.start_i   = 1'b1;
    bus.signed_i  = 1'b0;
    bus.annul_i   = 1'b0;
    bus.opdata1_i = 32'd5;
    bus.opdata2_i = 32'd1;
    #3;
    totalCount++;
    if (bus.ready_o !== 1'b0) $display("FAIL reset_ready: ready_o=%b required 0", bus.ready_o);
    else passCount++;
    totalCount++;
    if (bus.result_o !== 64'd0) $display("FAIL reset_result: result_o=%h required 0", bus.result_o);
    else passCount++;
    totalCount++;
    if (bus.stall_div_o !== 1'b0) $display("FAIL reset_stall: stall_div_o=%b required 0", bus.stall_div_o);
    else passCount++;
    bus.start_i = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    logic [31:0] va [5];
    logic [31:0] vb [5];
    logic        vs [5];
    logic [63:0] ve [5];
    logic [63:0] res;
    int          lat, stalls;
    va[0] = 32'd7;          vb[0] = 32'd2;          vs[0] = 1'b0; ve[0] = 64'h00000001_00000003;
    va[1] = 32'hFFFFFFF9;   vb[1] = 32'd2;          vs[1] = 1'b1; ve[1] = 64'hFFFFFFFF_FFFFFFFD;
    va[2] = 32'd7;          vb[2] = 32'hFFFFFFFE;   vs[2] = 1'b1; ve[2] = 64'h00000001_FFFFFFFD;
    va[3] = 32'h80000000;   vb[3] = 32'hFFFFFFFF;   vs[3] = 1'b1; ve[3] = 64'h00000000_80000000;
    va[4] = 32'hFFFFFFFF;   vb[4] = 32'd1;          vs[4] = 1'b0; ve[4] = 64'h00000000_FFFFFFFF;
    for (int i = 0; i < 5; i++) begin
      runOne(va[i], vb[i], vs[i], res, lat, stalls);
      totalCount++;
      if (res !== ve[i]) $display("FAIL directed_result[%0d]: result_o=%h required %h", i, res, ve[i]);
      else passCount++;
      totalCount++;
      if (lat !== 33) $display("FAIL directed_latency[%0d]: ready at cycle %0d required 33", i, lat);
      else passCount++;
      totalCount++;
      if (stalls !== 33) $display("FAIL directed_stall[%0d]: stall cycles %0d required 33", i, stalls);
      else passCount++;
      idleCycle();
    end
  endtask

  task automatic test_divzero();
    logic [63:0] res;
    int          lat, stalls;
    for (int s = 0; s < 2; s++) begin
      runOne($urandom, 32'd0, s[0], res, lat, stalls);
      totalCount++;
      if (res !== 64'd0) $display("FAIL divzero_result[%0d]: result_o=%h required 0", s, res);
      else passCount++;
      totalCount++;
      if (lat !== 2) $display("FAIL divzero_latency[%0d]: ready at cycle %0d required 2", s, lat);
      else passCount++;
      totalCount++;
      if (stalls !== 2) $display("FAIL divzero_stall[%0d]: stall cycles %0d required 2", s, stalls);
      else passCount++;
      idleCycle();
    end
  endtask

  // Annul pulsed at cycle ac of a divide: no stall that cycle, no ready pulse afterwards.
  task automatic annulRun(input int ac);
    int readys;
    bus.opdata1_i = $urandom;
    bus.opdata2_i = $urandom_range(1, 1000);
    bus.signed_i  = 1'b0;
    bus.start_i   = 1'b1;
    readys = 0;
    for (int c = 0; c < ac; c++) begin
      @(negedge clk);
      if (bus.ready_o === 1'b1) readys++;
      @(posedge clk);
      #1;
    end
    bus.annul_i = 1'b1;
    @(negedge clk);
    totalCount++;
    if (bus.stall_div_o !== 1'b0) $display("FAIL annul_stall[%0d]: stall_div_o=%b required 0", ac, bus.stall_div_o);
    else passCount++;
    totalCount++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0)
      $display("FAIL annul_output[%0d]: ready_o=%b result_o=%h required 0/0", ac, bus.ready_o, bus.result_o);
    else passCount++;
    @(posedge clk);
    #1;
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.ready_o === 1'b1) readys++;
      @(posedge clk);
      #1;
    end
    totalCount++;
    if (readys !== 0) $display("FAIL annul_no_ready[%0d]: ready pulses %0d required 0", ac, readys);
    else passCount++;
  endtask

  task automatic test_annul();
    logic [63:0] res;
    int          lat, stalls;
    annulRun(10);
    runOne(32'd100, 32'd7, 1'b0, res, lat, stalls);
    totalCount++;
    if (res !== 64'h00000002_0000000E) $display("FAIL annul_fresh_result: result_o=%h required 000000020000000e", res);
    else passCount++;
    totalCount++;
    if (lat !== 33) $display("FAIL annul_fresh_latency: ready at cycle %0d required 33", lat);
    else passCount++;
    idleCycle();
    annulRun(33);
  endtask

  task automatic test_back_to_back();
    logic [63:0] res1, res2;
    int          lat1, lat2, st1, st2;
    runOne(32'd9, 32'd4, 1'b0, res1, lat1, st1);
    runOne(32'd10, 32'd3, 1'b0, res2, lat2, st2);
    totalCount++;
    if (res1 !== 64'h00000001_00000002) $display("FAIL b2b_result1: result_o=%h required 0000000100000002", res1);
    else passCount++;
    totalCount++;
    if (res2 !== 64'h00000001_00000003) $display("FAIL b2b_result2: result_o=%h required 0000000100000003", res2);
    else passCount++;
    totalCount++;
    if (lat1 !== 33) $display("FAIL b2b_ready1: ready at cycle %0d required 33", lat1);
    else passCount++;
    totalCount++;
    if (lat1 + 1 + lat2 !== 67) $display("FAIL b2b_ready2: ready at cycle %0d required 67", lat1 + 1 + lat2);
    else passCount++;
    idleCycle();
  endtask

  task automatic test_reset_mid();
    logic [63:0] res;
    int          lat, stalls, readys;
    logic [31:0] a, b;
    bus.opdata1_i = $urandom;
    bus.opdata2_i = $urandom_range(1, 50);
    bus.signed_i  = 1'b0;
    bus.start_i   = 1'b1;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk);
      #1;
    end
    #2;
    resetn = 1'b0;
    #1;
    totalCount++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0 || bus.stall_div_o !== 1'b0)
      $display("FAIL reset_mid_outputs: ready=%b result=%h stall=%b required 0/0/0",
               bus.ready_o, bus.result_o, bus.stall_div_o);
    else passCount++;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    resetn = 1'b1;
    readys = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.ready_o === 1'b1) readys++;
      @(posedge clk);
      #1;
    end
    totalCount++;
    if (readys !== 0) $display("FAIL reset_mid_no_ready: ready pulses %0d required 0", readys);
    else passCount++;
    a = $urandom;
    b = $urandom_range(1, 100000);
    runOne(a, b, 1'b1, res, lat, stalls);
    totalCount++;
    if (res !== refDiv(a, b, 1'b1) || lat !== 33)
      $display("FAIL reset_mid_fresh: result=%h cycle=%0d required %h cycle 33", res, lat, refDiv(a, b, 1'b1));
    else passCount++;
    idleCycle();
  endtask

  task automatic test_random();
    logic [63:0] res, expRes;
    logic [31:0] a, b;
    logic        sgn;
    int          lat, stalls, expLat;
    for (int i = 0; i < 24; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'hFFFFFFFF;
        2: b = $urandom_range(1, 16);
        3: b = 32'h80000000;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h80000000;
      expRes = refDiv(a, b, sgn);
      expLat = (b == 32'd0) ? 2 : 33;
      runOne(a, b, sgn, res, lat, stalls);
      totalCount++;
      if (res !== expRes)
        $display("FAIL random_result[%0d]: a=%h b=%h s=%b result_o=%h required %h", i, a, b, sgn, res, expRes);
      else passCount++;
      totalCount++;
      if (lat !== expLat || stalls !== expLat)
        $display("FAIL random_timing[%0d]: ready cycle %0d stalls %0d required %0d/%0d", i, lat, stalls, expLat, expLat);
      else passCount++;
      idleCycle();
    end
  endtask

  initial begin
    passCount  = 0;
    totalCount = 0;
    test_reset();
    test_directed();
    test_divzero();
    test_annul();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
